hm01b0_stream_tx: RTL and testbench

//  Synthesizable HM01B0-style camera transmitter: drives pixclk/pixdata/hsync/vsync exactly as the jfpjc

---
 rtl/hm01b0_tx_pkg.sv | 24 ++
 rtl/hm01b0_pattern_gen.sv | 22 ++
 rtl/hm01b0_stream_tx.sv | 168 ++++++++++++++++
 tb/tb_hm01b0_stream_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hm01b0_tx_pkg.sv
// Shared pattern codes, FSM states and counter sizing for the HM01B0-style stream transmitter.
package hm01b0_tx_pkg;

  typedef enum logic [1:0] {
    PAT_CHECK1 = 2'd0,
    PAT_CHECK8 = 2'd1,
    PAT_XRAMP  = 2'd2,
    PAT_XYRAMP = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VFRONT,
    ST_LINE,
    ST_HBLANK,
    ST_VBACK
  } state_e;

  // Width of a counter stepping through n values 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hm01b0_pattern_gen.sv
// Combinational test-pattern source: (x, y, pattern) -> 8-bit pixel, no latency, no flow control.
module hm01b0_pattern_gen
  import hm01b0_tx_pkg::*;
(
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  pattern_e   i_pattern,
  output logic [7:0] o_pix
);

  always_comb begin
    o_pix = 8'h00;
    case (i_pattern)
      PAT_CHECK1: o_pix = (i_x[0] ^ i_y[0]) ? 8'hFF : 8'h00;
      PAT_CHECK8: o_pix = (i_x[3] ^ i_y[3]) ? 8'hFF : 8'h00;
      PAT_XRAMP:  o_pix = i_x;
      PAT_XYRAMP: o_pix = i_x + i_y;
      default:    o_pix = 8'h00;
    endcase
  end

endmodule

// File: rtl/hm01b0_stream_tx.sv
// HM01B0-style camera transmitter: free-running pixclk, frame/line timing FSM stepping on pixclk falls.
// Outputs are registered and change only on the clock edge where pixclk drops; no backpressure.
module hm01b0_stream_tx
  import hm01b0_tx_pkg::*;
#(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int H_BLANK = 16,
  parameter int V_FRONT = 8,
  parameter int V_BACK  = 32,
  parameter int CLKDIV  = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern_sel,
  output logic        o_pixclk,
  output logic [7:0]  o_pixdata,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_frame_done,
  output logic [15:0] o_frame_count
);

  localparam int DIV_W  = cnt_w(CLKDIV);
  localparam int X_W    = cnt_w(WIDTH);
  localparam int Y_W    = cnt_w(HEIGHT);
  localparam int B_MAX0 = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
  localparam int B_MAX  = (B_MAX0 > V_BACK) ? B_MAX0 : V_BACK;
  localparam int B_W    = cnt_w(B_MAX);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(HEIGHT - 1);
  // A zero-length blanking phase still occupies exactly one tick.
  localparam logic [B_W-1:0]   HB_LAST  = B_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [B_W-1:0]   VF_LAST  = B_W'((V_FRONT > 0) ? V_FRONT - 1 : 0);
  localparam logic [B_W-1:0]   VB_LAST  = B_W'((V_BACK > 0) ? V_BACK - 1 : 0);

  logic [DIV_W-1:0] r_div;
  logic             r_pixclk;
  state_e           r_state;
  pattern_e         r_pat;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [B_W-1:0]   r_cnt;
  logic [7:0]       r_pixdata;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_frame_done;
  logic [15:0]      r_frame_count;

  logic             w_tick;
  logic [7:0]       w_gen_x;
  logic [7:0]       w_gen_y;
  logic [7:0]       w_pix;

  assign w_tick = r_pixclk && (r_div == DIV_LAST);

  // The generator looks one pixel ahead: the value it produces is registered on the coming tick.
  always_comb begin
    w_gen_x = 8'd0;
    w_gen_y = 8'(r_y);
    case (r_state)
      ST_LINE:   w_gen_x = 8'(r_x) + 8'd1;
      ST_HBLANK: w_gen_y = 8'(r_y) + 8'd1;
      default:   ;
    endcase
  end

  hm01b0_pattern_gen u_pattern_gen (
    .i_x       (w_gen_x),
    .i_y       (w_gen_y),
    .i_pattern (r_pat),
    .o_pix     (w_pix)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_div         <= '0;
      r_pixclk      <= 1'b0;
      r_state       <= ST_IDLE;
      r_pat         <= PAT_CHECK1;
      r_x           <= '0;
      r_y           <= '0;
      r_cnt         <= '0;
      r_pixdata     <= 8'h00;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'h0000;
    end else begin
      r_frame_done <= 1'b0;
      if (r_div == DIV_LAST) begin
        r_div    <= '0;
        r_pixclk <= ~r_pixclk;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end

      if (w_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (i_enable) begin
              r_pat   <= pattern_e'(i_pattern_sel);
              r_x     <= '0;
              r_y     <= '0;
              r_cnt   <= '0;
              r_vsync <= 1'b1;
              r_state <= ST_VFRONT;
            end
          end
          ST_VFRONT: begin
            if (r_cnt == VF_LAST) begin
              r_hsync   <= 1'b1;
              r_pixdata <= w_pix;
              r_x       <= '0;
              r_state   <= ST_LINE;
            end else begin
              r_cnt <= r_cnt + B_W'(1);
            end
          end
          ST_LINE: begin
            if (r_x == X_LAST) begin
              r_hsync   <= 1'b0;
              r_pixdata <= 8'h00;
              r_cnt     <= '0;
              r_state   <= ST_HBLANK;
            end else begin
              r_x       <= r_x + X_W'(1);
              r_pixdata <= w_pix;
            end
          end
          ST_HBLANK: begin
            if (r_cnt != HB_LAST) begin
              r_cnt <= r_cnt + B_W'(1);
            end else if (r_y != Y_LAST) begin
              r_y       <= r_y + Y_W'(1);
              r_x       <= '0;
              r_hsync   <= 1'b1;
              r_pixdata <= w_pix;
              r_state   <= ST_LINE;
            end else begin
              r_vsync       <= 1'b0;
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + 16'd1;
              r_cnt         <= '0;
              r_state       <= ST_VBACK;
            end
          end
          ST_VBACK: begin
            if (r_cnt == VB_LAST) r_state <= ST_IDLE;
            else                  r_cnt   <= r_cnt + B_W'(1);
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_pixclk      = r_pixclk;
  assign o_pixdata     = r_pixdata;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_frame_done  = r_frame_done;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_hm01b0_stream_tx.sv
// Bench for hm01b0_stream_tx: a receiver model samples on pixclk rise and compares each frame
// against a reference stream built from the pixel formulas and blanking lengths.
module tb_hm01b0_stream_tx;
  localparam int W  = 24;
  localparam int H  = 18;
  localparam int HB = 2;
  localparam int VF = 0;
  localparam int VB = 3;
  localparam int CD = 2;
  localparam int HB_T = (HB == 0) ? 1 : HB;
  localparam int VF_T = (VF == 0) ? 1 : VF;
  localparam int VB_T = (VB == 0) ? 1 : VB;
  localparam int FRAME_CLK = 2 * CD * (VF_T + H * (W + HB_T) + VB_T + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        pixclk, hsync, vsync, frame_done;
  logic [7:0]  pixdata;
  logic [15:0] frame_count;

  hm01b0_stream_tx #(
    .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_FRONT(VF), .V_BACK(VB), .CLKDIV(CD)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_pattern_sel (sel),
    .o_pixclk      (pixclk),
    .o_pixdata     (pixdata),
    .o_hsync       (hsync),
    .o_vsync       (vsync),
    .o_frame_done  (frame_done),
    .o_frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference pixel values, written as plain arithmetic on coordinates.
  function automatic logic [7:0] ref_pix(input int x, input int y, input int p);
    case (p)
      0:       return (((x + y) % 2) == 1) ? 8'hFF : 8'h00;
      1:       return ((((x / 8) + (y / 8)) % 2) == 1) ? 8'hFF : 8'h00;
      2:       return 8'(x % 256);
      default: return 8'((x + y) % 256);
    endcase
  endfunction

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic [7:0] pd;
  } smp_t;

  smp_t exp_q[$];
  smp_t mon_s, mon_e;
  bit   mon_on = 1'b0;
  bit   gap_exact = 1'b0;
  int   gap = 1000;
  int   frames_started = 0;
  int   exp_frames = 0;
  logic prv_vs = 1'b0;

  task automatic build_frame(input int p);
    for (int i = 0; i < VF_T; i++) exp_q.push_back(smp_t'({1'b1, 1'b0, 8'h00}));
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) exp_q.push_back(smp_t'({1'b1, 1'b1, ref_pix(x, y, p)}));
      for (int i = 0; i < HB_T; i++) exp_q.push_back(smp_t'({1'b1, 1'b0, 8'h00}));
    end
  endtask

  // Receiver: one sample per pixel period, taken just after pixclk rises.
  always begin
    @(posedge pixclk);
    #1;
    if (mon_on) begin
      mon_s = '{vsync, hsync, pixdata};
      if (exp_q.size() == 0 && vsync) begin
        if (gap_exact) check_eq("vback_gap", 32'(gap), 32'(VB_T + 1));
        else           check_eq("vback_gap_min", 32'(gap >= VB_T + 1), 32'd1);
        frames_started++;
        build_frame(int'(sel));
        gap = 0;
      end
      if (exp_q.size() == 0) begin
        gap++;
        check_eq("idle_hs_pd", 32'({hsync, pixdata}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("frame_sample", 32'(mon_s), 32'(mon_e));
      end
    end
  end

  // frame_done must coincide exactly with the clock where vsync falls.
  always @(negedge clk) begin
    if (rst) begin
      prv_vs     = 1'b0;
      exp_frames = 0;
    end else begin
      if (frame_done || (prv_vs && !vsync)) begin
        check_eq("frame_done_pulse", 32'(frame_done), 32'(prv_vs && !vsync));
        if (prv_vs && !vsync) exp_frames++;
        check_eq("frame_count", 32'(frame_count), 32'(exp_frames));
      end
      prv_vs = vsync;
    end
  end

  task automatic wait_frames(input int target, input string tag);
    int cyc = 0;
    while (exp_frames < target && cyc < 3 * FRAME_CLK) begin
      @(negedge clk);
      cyc++;
    end
    check_eq(tag, 32'(exp_frames >= target), 32'd1);
  endtask

  initial begin
    int r1, r2, cyc;
    logic pv;

    rst = 1'b1; en = 1'b0; sel = 2'd0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_pixclk", 32'(pixclk), 32'd0);
    check_eq("rst_pixdata", 32'(pixdata), 32'd0);
    check_eq("rst_hsync", 32'(hsync), 32'd0);
    check_eq("rst_vsync", 32'(vsync), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_frame_count", 32'(frame_count), 32'd0);
    rst = 1'b0;
    mon_on = 1'b1;

    // pixclk runs while idle with enable low
    r1 = -1; r2 = -1; pv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pixclk && !pv) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      pv = pixclk;
    end
    check_eq("pixclk_period", 32'(r2 - r1), 32'(2 * CD));
    check_eq("idle_no_vsync", 32'(vsync), 32'd0);

    // back-to-back frames: 1px checker, 8x8 checker, then random patterns
    sel = 2'd0; en = 1'b1;
    wait_frames(1, "frame1_done");
    gap_exact = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      sel = (k == 2) ? 2'd1 : 2'($urandom_range(0, 3));
      wait_frames(k, "frame_done_seq");
    end

    // pattern change mid-frame only takes effect at the next frame
    sel = 2'd2;
    repeat (FRAME_CLK / 2) @(negedge clk);
    sel = 2'd3;
    wait_frames(5, "frame5_xramp");
    wait_frames(6, "frame6_xyramp");

    // enable dropped mid-frame: frame completes, nothing follows
    sel = 2'($urandom_range(0, 3));
    repeat (FRAME_CLK / 2) @(negedge clk);
    en = 1'b0;
    gap_exact = 1'b0;
    wait_frames(7, "frame7_after_drop");
    repeat (2 * FRAME_CLK) @(negedge clk);
    check_eq("no_restart_vsync", 32'(vsync), 32'd0);
    check_eq("frames_started_drop", 32'(frames_started), 32'd7);
    check_eq("frame_count_drop", 32'(frame_count), 32'd7);

    // reset in the middle of an active line
    sel = 2'd3; en = 1'b1;
    cyc = 0;
    while (!hsync && cyc < 3 * FRAME_CLK) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("line_reached", 32'(hsync), 32'd1);
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_hsync", 32'(hsync), 32'd0);
    check_eq("arst_vsync", 32'(vsync), 32'd0);
    check_eq("arst_pixdata", 32'(pixdata), 32'd0);
    check_eq("arst_pixclk", 32'(pixclk), 32'd0);
    check_eq("arst_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    gap = 1000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    wait_frames(1, "post_reset_frame");
    check_eq("post_reset_count", 32'(frame_count), 32'd1);
    check_eq("post_reset_started", 32'(frames_started), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
